bubsys_ioctl_loader: RTL and testbench

//  Consumes the hps_io ioctl download stream. Packs ROM bytes into big-endian 16-bit words
//  and buffers them in a small FIFO. Issues word writes to the SDRAM ROM-store request port.

---
 rtl/bubsys_ioctl_loader_if.sv | 27 ++
 rtl/bubsys_ioctl_loader.sv | 195 +++++++++++++++++++
 tb/tb_bubsys_ioctl_loader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/bubsys_ioctl_loader_if.sv
// ROM-store write request bus between the ioctl loader and the SDRAM side.
// The loader drives the request side; the SDRAM controller acknowledges.
interface bubsys_ioctl_loader_if #(
  parameter int ADDR_W = 24
);
  logic              o_WR_REQ;
  logic [ADDR_W-1:0] o_WR_ADDR;
  logic [15:0]       o_WR_DATA;
  logic [1:0]        o_WR_BE;
  logic              i_WR_ACK;

  modport master (
    output o_WR_REQ,
    output o_WR_ADDR,
    output o_WR_DATA,
    output o_WR_BE,
    input  i_WR_ACK
  );

  modport slave (
    input  o_WR_REQ,
    input  o_WR_ADDR,
    input  o_WR_DATA,
    input  o_WR_BE,
    output i_WR_ACK
  );
endinterface

// File: rtl/bubsys_ioctl_loader.sv
// hps_io ioctl download sink: packs ROM bytes into big-endian words,
// queues them for SDRAM, throttles the HPS and captures DIP bytes.
module bubsys_ioctl_loader #(
  parameter logic [15:0] ROM_INDEX  = 16'd0,
  parameter logic [15:0] DIP_INDEX  = 16'd254,
  parameter int          FIFO_DEPTH = 8,
  parameter int          ADDR_W     = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic        i_EMU_CLK72M,
  input  logic        i_EMU_INITRST,
  input  logic        ioctl_download,
  input  logic [15:0] ioctl_index,
  input  logic [26:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic        ioctl_wait,
  bubsys_ioctl_loader_if.master wr,
  output logic [31:0] o_DIP,
  output logic        o_BUSY,
  output logic        o_ROM_READY,
  output logic        o_OVF
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int WL = FIFO_DEPTH - 2;
  localparam logic [PW:0] FULL_LVL = FIFO_DEPTH[PW:0];
  localparam logic [PW:0] WAIT_LVL = WL[PW:0];

  typedef enum logic [1:0] {
    IDLE, LOAD, FLUSH, DONE
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic [1:0]        be;
  } ent_t;

  state_e state_q, state_d;
  ent_t   mem_q [FIFO_DEPTH];
  logic [PW:0] wp_q, rp_q, wp_d, rp_d;
  logic [PW:0] cnt_q, cnt_d;
  ent_t   pend_q, pend_d;
  logic   pend_v_q, pend_v_d;
  ent_t   defer_q, defer_d;
  logic   defer_v_q, defer_v_d;
  logic   wait_q, wait_d;
  logic   ovf_q, ready_q;
  logic [31:0] dip_q;

  logic [ADDR_W-1:0] waddr;
  logic   byte_ok, hit, full, pop, push_ok;
  logic   e1_v, e2_v, push_v, drop, clr;
  ent_t   e1, e2, lo_e, push_e;
  logic   unused_addr;

  assign unused_addr = ^ioctl_addr[26:ADDR_W+1];

  assign waddr   = BASE_ADDR + ioctl_addr[ADDR_W:1];
  assign lo_e    = {waddr, 8'h00, ioctl_data, 2'b01};
  assign byte_ok = (state_q == LOAD) && ioctl_wr
                 && (ioctl_index == ROM_INDEX);
  assign hit     = pend_v_q && (pend_q.addr == waddr);
  assign cnt_q   = wp_q - rp_q;
  assign full    = (cnt_q == FULL_LVL);
  assign pop     = (cnt_q != '0) && wr.i_WR_ACK;
  assign push_ok = push_v && !full;
  assign wp_d    = wp_q + {{PW{1'b0}}, push_ok};
  assign rp_d    = rp_q + {{PW{1'b0}}, pop};
  assign cnt_d   = wp_d - rp_d;
  assign wait_d  = (cnt_d >= WAIT_LVL) || defer_v_d;

  always_comb begin
    e1_v     = 1'b0;
    e2_v     = 1'b0;
    e1       = '0;
    e2       = '0;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (byte_ok) begin
      if (!ioctl_addr[0]) begin
        e1_v     = pend_v_q;
        e1       = pend_q;
        pend_v_d = 1'b1;
        pend_d   = {waddr, ioctl_data, 8'h00, 2'b10};
      end else if (hit) begin
        e1_v     = 1'b1;
        e1       = {waddr, pend_q.data[15:8], ioctl_data, 2'b11};
        pend_v_d = 1'b0;
      end else if (pend_v_q) begin
        e1_v     = 1'b1;
        e1       = pend_q;
        e2_v     = 1'b1;
        e2       = lo_e;
        pend_v_d = 1'b0;
      end else begin
        e1_v = 1'b1;
        e1   = lo_e;
      end
    end else if (state_q == FLUSH && pend_v_q) begin
      e1_v     = 1'b1;
      e1       = pend_q;
      pend_v_d = 1'b0;
    end
    // A deferred entry always owns this cycle's single push slot.
    drop = 1'b0;
    if (defer_v_q) begin
      push_v    = 1'b1;
      push_e    = defer_q;
      defer_v_d = e1_v;
      defer_d   = e1;
      drop      = e2_v;
    end else begin
      push_v    = e1_v;
      push_e    = e1;
      defer_v_d = e2_v;
      defer_d   = e2;
    end
  end

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ioctl_download && ioctl_index == ROM_INDEX) begin
          state_d = LOAD;
          clr     = 1'b1;
        end
      end
      LOAD: begin
        if (!ioctl_download) state_d = FLUSH;
      end
      FLUSH: begin
        if (cnt_q == '0 && !pend_v_q && !defer_v_q)
          state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_EMU_CLK72M) begin
    if (i_EMU_INITRST) begin
      state_q   <= IDLE;
      wp_q      <= '0;
      rp_q      <= '0;
      pend_q    <= '0;
      pend_v_q  <= 1'b0;
      defer_q   <= '0;
      defer_v_q <= 1'b0;
      wait_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      defer_q   <= defer_d;
      defer_v_q <= defer_v_d;
      wait_q    <= wait_d;
      ovf_q     <= clr ? 1'b0
                 : (ovf_q | (push_v && full) | drop);
      ready_q   <= clr ? 1'b0
                 : (ready_q | (state_q == DONE));
    end
  end

  always_ff @(posedge i_EMU_CLK72M) begin
    if (push_ok) mem_q[wp_q[PW-1:0]] <= push_e;
  end

  always_ff @(posedge i_EMU_CLK72M) begin
    if (i_EMU_INITRST) begin
      dip_q <= '0;
    end else if (ioctl_wr && ioctl_index == DIP_INDEX
                 && ioctl_addr < 27'd4) begin
      dip_q[{ioctl_addr[1:0], 3'b000} +: 8] <= ioctl_data;
    end
  end

  assign wr.o_WR_REQ  = (cnt_q != '0);
  assign wr.o_WR_ADDR = mem_q[rp_q[PW-1:0]].addr;
  assign wr.o_WR_DATA = mem_q[rp_q[PW-1:0]].data;
  assign wr.o_WR_BE   = mem_q[rp_q[PW-1:0]].be;
  assign ioctl_wait   = wait_q;
  assign o_DIP        = dip_q;
  assign o_BUSY       = (state_q == LOAD) || (state_q == FLUSH);
  assign o_ROM_READY  = ready_q;
  assign o_OVF        = ovf_q;

endmodule

// File: tb/tb_bubsys_ioctl_loader.sv
// Directed bench for bubsys_ioctl_loader: packing, flush, throttle,
// overflow, DIP capture, deferred push and reset mid-load.
module tb_bubsys_ioctl_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dl = 1'b0;
  logic [15:0] idx = 16'd0;
  logic [26:0] addr = '0;
  logic [7:0]  data = '0;
  logic        iwr = 1'b0;
  logic        iwait;
  logic [31:0] dip;
  logic        busy, rdy, ovf;

  int n_chk = 0;
  int n_fail = 0;
  logic [41:0] got_q [$];

  bubsys_ioctl_loader_if #(.ADDR_W(24)) wif ();

  bubsys_ioctl_loader dut (
    .i_EMU_CLK72M  (clk),
    .i_EMU_INITRST (rst),
    .ioctl_download(dl),
    .ioctl_index   (idx),
    .ioctl_addr    (addr),
    .ioctl_data    (data),
    .ioctl_wr      (iwr),
    .ioctl_wait    (iwait),
    .wr            (wif),
    .o_DIP         (dip),
    .o_BUSY        (busy),
    .o_ROM_READY   (rdy),
    .o_OVF         (ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && wif.o_WR_REQ && wif.i_WR_ACK)
      got_q.push_back({wif.o_WR_ADDR, wif.o_WR_DATA, wif.o_WR_BE});

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [41:0] ent(input int a,
                                      input logic [15:0] d,
                                      input logic [1:0] be);
    return {24'(a), d, be};
  endfunction

  function automatic logic [41:0] gw(input int i);
    return (i < got_q.size()) ? got_q[i] : '1;
  endfunction

  task automatic send(input logic [15:0] ix, input int a,
                      input logic [7:0] d, input bit honor);
    int n = 0;
    if (honor)
      while (iwait && n < 200) begin
        tick();
        n++;
      end
    if (honor && n >= 200) check("wait_timeout", iwait, 0);
    idx  = ix;
    addr = 27'(a);
    data = d;
    iwr  = 1'b1;
    tick();
    iwr  = 1'b0;
  endtask

  task automatic start_load();
    got_q.delete();
    idx = 16'd0;
    dl  = 1'b1;
    tick();
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!rdy && n < 100) begin
      tick();
      n++;
    end
    check(tag, rdy, 1);
  endtask

  initial begin
    wif.i_WR_ACK = 1'b1;
    tick();
    tick();
    check("rst_req", wif.o_WR_REQ, 0);
    check("rst_busy", busy, 0);
    check("rst_rdy", rdy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_wait", iwait, 0);
    check("rst_dip", dip, 0);
    rst = 1'b0;
    tick();

    // 1: even word pairs, ACK tied high
    start_load();
    check("t1_busy", busy, 1);
    send(0, 0, 8'h12, 1);
    send(0, 1, 8'h34, 1);
    send(0, 2, 8'h56, 1);
    send(0, 3, 8'h78, 1);
    dl = 1'b0;
    wait_ready("t1_rdy");
    check("t1_n", got_q.size(), 2);
    check("t1_w0", gw(0), ent(0, 16'h1234, 2'b11));
    check("t1_w1", gw(1), ent(1, 16'h5678, 2'b11));
    tick();
    check("t1_idle", busy, 0);

    // 2: odd length, trailing byte flushed
    start_load();
    check("t2_rdyclr", rdy, 0);
    send(0, 0, 8'hAA, 1);
    send(0, 1, 8'hBB, 1);
    send(0, 2, 8'hCC, 1);
    dl = 1'b0;
    wait_ready("t2_rdy");
    check("t2_n", got_q.size(), 2);
    check("t2_w0", gw(0), ent(0, 16'hAABB, 2'b11));
    check("t2_w1", gw(1), ent(1, 16'hCC00, 2'b10));

    // 3: back-pressure with ACK held low
    wif.i_WR_ACK = 1'b0;
    start_load();
    for (int i = 0; i < 10; i++) send(0, i, 8'(8'h10 + i), 1);
    check("t3_wait5", iwait, 0);
    send(0, 10, 8'h1A, 1);
    send(0, 11, 8'h1B, 1);
    check("t3_wait6", iwait, 1);
    repeat (4) tick();
    check("t3_hold", iwait, 1);
    check("t3_none", got_q.size(), 0);
    wif.i_WR_ACK = 1'b1;
    for (int i = 12; i < 16; i++) send(0, i, 8'(8'h10 + i), 1);
    dl = 1'b0;
    wait_ready("t3_rdy");
    check("t3_n", got_q.size(), 8);
    for (int k = 0; k < 8; k++)
      check($sformatf("t3_w%0d", k), gw(k),
            ent(k, {8'(8'h10 + 2*k), 8'(8'h11 + 2*k)}, 2'b11));
    check("t3_ovf", ovf, 0);

    // 4: overflow when HPS ignores wait
    wif.i_WR_ACK = 1'b0;
    start_load();
    for (int i = 0; i < 16; i++) send(0, i, 8'(8'h40 + i), 0);
    check("t4_ovf0", ovf, 0);
    send(0, 16, 8'h50, 0);
    send(0, 17, 8'h51, 0);
    check("t4_ovf1", ovf, 1);
    check("t4_req", wif.o_WR_REQ, 1);
    wif.i_WR_ACK = 1'b1;
    dl = 1'b0;
    wait_ready("t4_rdy");
    check("t4_n", got_q.size(), 8);
    for (int k = 0; k < 8; k++)
      check($sformatf("t4_w%0d", k), gw(k),
            ent(k, {8'(8'h40 + 2*k), 8'(8'h41 + 2*k)}, 2'b11));
    check("t4_ovfkeep", ovf, 1);

    // 5: DIP capture, ROM FSM untouched
    idx = 16'd254;
    dl  = 1'b1;
    tick();
    send(254, 0, 8'hFE, 1);
    send(254, 1, 8'h01, 1);
    send(254, 2, 8'h80, 1);
    send(254, 3, 8'h7F, 1);
    send(254, 4, 8'hEE, 1);
    check("t5_dip", dip, 32'h7F8001FE);
    check("t5_busy", busy, 0);
    check("t5_wait", iwait, 0);
    dl = 1'b0;
    tick();

    // 7: unpaired bytes and a deferred push
    start_load();
    send(0, 5, 8'h55, 1);
    send(0, 6, 8'h66, 1);
    send(0, 8, 8'h88, 1);
    send(0, 11, 8'hBB, 1);
    check("t7_wdef", iwait, 1);
    dl = 1'b0;
    wait_ready("t7_rdy");
    check("t7_n", got_q.size(), 4);
    check("t7_w0", gw(0), ent(2, 16'h0055, 2'b01));
    check("t7_w1", gw(1), ent(3, 16'h6600, 2'b10));
    check("t7_w2", gw(2), ent(4, 16'h8800, 2'b10));
    check("t7_w3", gw(3), ent(5, 16'h00BB, 2'b01));
    check("t7_ovf", ovf, 0);

    // 6: reset with words queued
    wif.i_WR_ACK = 1'b0;
    start_load();
    for (int i = 0; i < 6; i++) send(0, i, 8'(8'h20 + i), 1);
    check("t6_req1", wif.o_WR_REQ, 1);
    rst = 1'b1;
    dl  = 1'b0;
    tick();
    check("t6_req0", wif.o_WR_REQ, 0);
    check("t6_busy", busy, 0);
    check("t6_rdy", rdy, 0);
    rst = 1'b0;
    wif.i_WR_ACK = 1'b1;
    tick();
    check("t6_noreq", got_q.size(), 0);
    start_load();
    send(0, 0, 8'h5A, 1);
    send(0, 1, 8'hA5, 1);
    dl = 1'b0;
    wait_ready("t6_rdy2");
    check("t6_n", got_q.size(), 1);
    check("t6_w0", gw(0), ent(0, 16'h5AA5, 2'b11));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
